button_debouncer_2ch: RTL

//   Front-end input stage for the two-input decoder that produces `out` from `a`/`b`.

---
 rtl/button_debouncer_2ch_pkg.sv | 15 +
 rtl/button_debouncer_2ch_debounce_channel.sv | 111 +++++++++++
 rtl/button_debouncer_2ch.sv | 54 +++++
 3 files changed

// File: rtl/button_debouncer_2ch_pkg.sv
// Shared definitions for the two-channel pushbutton debouncer:
// per-channel state encoding and default parameter values.
package button_debouncer_2ch_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 3;

    // A channel is either quiet (output matches input) or counting toward a flip.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/button_debouncer_2ch_debounce_channel.sv
// One debounce channel: synchroniser chain, stability counter FSM,
// registered debounced level and one-cycle change strobe.
module debounce_channel
    import button_debouncer_2ch_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw,
    output logic       q,
    output logic       changed,
    output deb_state_e state
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               IMMEDIATE = (STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    deb_state_e             state_q;
    deb_state_e             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   lvl_q;
    logic                   lvl_d;
    logic                   strobe_q;
    logic                   strobe_d;

    logic sq;
    logic differ;
    logic flip;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = raw;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign sq     = sync_q[SYNC_STAGES-1];
    assign differ = (sq != lvl_q);

    // State register: every flop, including the synchroniser, clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            lvl_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lvl_q    <= lvl_d;
            strobe_q <= strobe_d;
        end
    end

    // Next-state and counter logic; counter is cleared on every return to STABLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (differ && !IMMEDIATE) begin
                    state_d = ST_PENDING;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PENDING: begin
                if (!differ || (cnt_q == CNT_LAST)) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: the level and its strobe are registered on the same edge.
    always_comb begin
        flip = 1'b0;
        case (state_q)
            ST_STABLE:  flip = differ && IMMEDIATE;
            ST_PENDING: flip = differ && (cnt_q == CNT_LAST);
            default:    flip = 1'b0;
        endcase
        lvl_d    = flip ? sq : lvl_q;
        strobe_d = flip;
    end

    assign q       = lvl_q;
    assign changed = strobe_q;
    assign state   = state_q;

endmodule

// File: rtl/button_debouncer_2ch.sv
// Two independent debounce channels feeding the a/b decoder, plus a
// combinational "settled" flag that is high when neither channel is counting.
module button_debouncer_2ch
    import button_debouncer_2ch_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_changed,
    output logic b_changed,
    output logic settled
);

    logic [1:0] raw_vec;
    logic [1:0] q_vec;
    logic [1:0] chg_vec;
    logic [1:0] stable_vec;
    deb_state_e ch_state [2];

    assign raw_vec = {b_raw, a_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES  (SYNC_STAGES),
                .STABLE_CYCLES(STABLE_CYCLES),
                .CNT_W        (CNT_W)
            ) u_channel (
                .clk    (clk),
                .rst    (rst),
                .raw    (raw_vec[gi]),
                .q      (q_vec[gi]),
                .changed(chg_vec[gi]),
                .state  (ch_state[gi])
            );
            assign stable_vec[gi] = (ch_state[gi] == ST_STABLE);
        end
    endgenerate

    assign a         = q_vec[0];
    assign b         = q_vec[1];
    assign a_changed = chg_vec[0];
    assign b_changed = chg_vec[1];
    assign settled   = &stable_vec;

endmodule
